// File: rtl/cim_seq_pkg.sv
// Shared types and constants for the one-bit CIM column sequencer.
package cim_seq_pkg;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ_Q  = 2'b01,
    OP_READ_QB = 2'b10,
    OP_ILLEGAL = 2'b11
  } cim_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_PRE   = 3'd2,
    ST_SMP   = 3'd3,
    ST_SA    = 3'd4,
    ST_SMPSA = 3'd5,
    ST_RST   = 3'd6
  } cim_seq_state_e;

  typedef struct packed {
    logic preb;
    logic w_en;
    logic sampleb;
    logic sae;
    logic wl;
    logic wlb;
  } cim_ctrl_t;

  // Column parked: precharge on, sampling off, no wordline or sense activity.
  localparam cim_ctrl_t CTRL_IDLE = '{preb: 1'b0, w_en: 1'b0, sampleb: 1'b1,
                                      sae: 1'b0, wl: 1'b0, wlb: 1'b0};

  function automatic int max5(input int a, input int b, input int c,
                              input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/cim_phase_timer.sv
// Loadable down-counter timing one sequencer phase; done_o while the count is zero.
module cim_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load on phase entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/cim_bitcell_seq.sv
// Write/read phase sequencer for the one-bit CIM column; all column controls registered.
// Optional merged sample+sense path is built only when CIM_SEQ_MERGED_SENSE_EN is defined.
module cim_bitcell_seq
  import cim_seq_pkg::*;
#(
  parameter int T_WR  = 2,
  parameter int T_PRE = 2,
  parameter int T_SMP = 2,
  parameter int T_SA  = 2,
  parameter int T_RST = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_wdata,
  input  logic       cmd_merged,
  input  logic       sa_out,
  output logic       rsp_valid,
  output logic       rsp_data,
  output logic       rsp_err,
  output logic       preb,
  output logic       w_en,
  output logic       write_bit,
  output logic       sampleb,
  output logic       SAE,
  output logic       WL,
  output logic       WLB
);

  localparam int T_MAX = max5(T_WR, T_PRE, T_SMP, T_SA, T_RST);
  localparam int CW    = $clog2(T_MAX) + 1;

  localparam logic [CW-1:0] LD_WR  = CW'(T_WR - 1);
  localparam logic [CW-1:0] LD_PRE = CW'(T_PRE - 1);
  localparam logic [CW-1:0] LD_SMP = CW'(T_SMP - 1);
  localparam logic [CW-1:0] LD_SA  = CW'(T_SA - 1);
  localparam logic [CW-1:0] LD_RST = CW'(T_RST - 1);

  cim_seq_state_e state_q, state_d;
  cim_op_e        op_q, op_d;
  cim_op_e        cmd_op_s;
  cim_ctrl_t      ctrl_q, ctrl_d;
  logic           write_bit_q, write_bit_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;
  logic           accept_s;
  logic           ld_s;
  logic [CW-1:0]  ld_val_s;
  logic           done_s;

`ifdef CIM_SEQ_MERGED_SENSE_EN
  logic merged_q, merged_d;
`else
  logic unused_merged_s;
  assign unused_merged_s = cmd_merged;
`endif

  assign cmd_op_s = cim_op_e'(cmd_op);
  assign accept_s = cmd_valid & cmd_ready_q;

  cim_phase_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ld_s),
    .load_val_i (ld_val_s),
    .done_o     (done_s)
  );

  // Phase sequencing, command latching and response generation.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    write_bit_d = write_bit_q;
    ld_s        = 1'b0;
    ld_val_s    = {CW{1'b0}};
    rsp_valid_d = 1'b0;
    rsp_data_d  = 1'b0;
    rsp_err_d   = 1'b0;
`ifdef CIM_SEQ_MERGED_SENSE_EN
    merged_d    = merged_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d = cmd_op_s;
`ifdef CIM_SEQ_MERGED_SENSE_EN
          merged_d = cmd_merged;
`endif
          case (cmd_op_s)
            OP_WRITE: begin
              state_d     = ST_WRITE;
              ld_s        = 1'b1;
              ld_val_s    = LD_WR;
              write_bit_d = cmd_wdata;
            end
            OP_READ_Q, OP_READ_QB: begin
              state_d  = ST_PRE;
              ld_s     = 1'b1;
              ld_val_s = LD_PRE;
            end
            default: begin
              // Illegal opcode: straight to RST, column never leaves the parked state.
              state_d     = ST_RST;
              ld_s        = 1'b1;
              ld_val_s    = LD_RST;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (done_s) begin
          state_d     = ST_RST;
          ld_s        = 1'b1;
          ld_val_s    = LD_RST;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_PRE: begin
        if (done_s) begin
          ld_s     = 1'b1;
          ld_val_s = LD_SMP;
`ifdef CIM_SEQ_MERGED_SENSE_EN
          if (merged_q) begin
            state_d = ST_SMPSA;
          end else begin
            state_d = ST_SMP;
          end
`else
          state_d = ST_SMP;
`endif
        end else begin
          state_d = ST_PRE;
        end
      end
      ST_SMP: begin
        if (done_s) begin
          state_d  = ST_SA;
          ld_s     = 1'b1;
          ld_val_s = LD_SA;
        end else begin
          state_d = ST_SMP;
        end
      end
`ifdef CIM_SEQ_MERGED_SENSE_EN
      ST_SA, ST_SMPSA: begin
`else
      ST_SA: begin
`endif
        if (done_s) begin
          state_d     = ST_RST;
          ld_s        = 1'b1;
          ld_val_s    = LD_RST;
          rsp_valid_d = 1'b1;
          rsp_data_d  = sa_out ^ (op_q == OP_READ_QB);
        end else begin
          state_d = state_q;
        end
      end
      ST_RST: begin
        if (done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Column control word for the state being entered, so outputs change with the state.
  always_comb begin
    ctrl_d = CTRL_IDLE;
    case (state_d)
      ST_WRITE: ctrl_d = '{preb: 1'b1, w_en: 1'b1, sampleb: 1'b1,
                           sae: 1'b0, wl: 1'b1, wlb: 1'b1};
      ST_SMP:   ctrl_d = '{preb: 1'b1, w_en: 1'b0, sampleb: 1'b0, sae: 1'b0,
                           wl: (op_d == OP_READ_Q), wlb: (op_d == OP_READ_QB)};
      ST_SA:    ctrl_d = '{preb: 1'b1, w_en: 1'b0, sampleb: 1'b1,
                           sae: 1'b1, wl: 1'b0, wlb: 1'b0};
`ifdef CIM_SEQ_MERGED_SENSE_EN
      ST_SMPSA: ctrl_d = '{preb: 1'b1, w_en: 1'b0, sampleb: 1'b0, sae: 1'b1,
                           wl: (op_d == OP_READ_Q), wlb: (op_d == OP_READ_QB)};
`endif
      default:  ctrl_d = CTRL_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and registered outputs; reset parks the column and drops any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_WRITE;
      ctrl_q      <= CTRL_IDLE;
      write_bit_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef CIM_SEQ_MERGED_SENSE_EN
      merged_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ctrl_q      <= ctrl_d;
      write_bit_q <= write_bit_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef CIM_SEQ_MERGED_SENSE_EN
      merged_q    <= merged_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign preb      = ctrl_q.preb;
  assign w_en      = ctrl_q.w_en;
  assign write_bit = write_bit_q;
  assign sampleb   = ctrl_q.sampleb;
  assign SAE       = ctrl_q.sae;
  assign WL        = ctrl_q.wl;
  assign WLB       = ctrl_q.wlb;

endmodule
